up_down_counter_param: RTL

//   Synchronous, parametrised up/down counter. Successor to the 3-bit JK ripple
//   up/down counter: configurable width and modulus, wrap or saturate at terminal

---
 rtl/up_down_counter_param.sv | 72 +++++++
 1 files changed

// File: rtl/up_down_counter_param.sv
// Synchronous up/down counter with configurable width, modulus and wrap/saturate
// behaviour. Synchronous clear and load, a count enable, and a registered wrap pulse.
module up_down_counter_param #(
  parameter int unsigned     WIDTH    = 3,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             m,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrap
);

  // Top of the count range, truncated to WIDTH bits so that a full-range modulus
  // yields all-ones and the natural overflow matches the explicit wrap.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_step;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);
  assign tc      = m ? at_max : at_zero;
  assign count_n = ~count;

  always_comb begin
    load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    count_step   = m ? (count + WIDTH'(1)) : (count - WIDTH'(1));
  end

  // clr > load > en > hold; the terminal case either wraps or holds.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (clr) begin
      count_next = '0;
    end else if (load) begin
      count_next = load_clamped;
    end else if (en) begin
      if (tc) begin
        wrap_next = 1'b1;
        if (!SATURATE) begin
          count_next = m ? '0 : MAX_VAL;
        end
      end else begin
        count_next = count_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule
